dma_write_master_p: RTL and testbench
=====================================

DMA_WRITE_MASTER_P -- requirements
Module: dma_write_master_p

Interface
REQ-001 SHALL have parameter DATA_W, default 32, Avalon/FIFO data width; legal 32, 64, 128.
REQ-002 SHALL have parameter ADDR_W, default 32, Avalon address width.
REQ-003 SHALL have parameter LEN_W, default 32, byte-length counter width.
REQ-004 SHALL have ports: iClk  in  1  clock (one clock); iReset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: Start  in  1  launch transfer; Abort  in  1  stop after current beat; Length  in  LEN_W  bytes to write; WM_startaddress  in  ADDR_W  byte start address, DATA_W/8-aligned.
REQ-006 SHALL have ports: FF_empty  in  1; FF_readrequest  out  1; FF_q  in  DATA_W  (data valid one cycle after readrequest).
REQ-007 SHALL have ports: oWM_write  out  1; oWM_writeaddress  out  ADDR_W; oWM_writedata  out  DATA_W; oWM_byteenable  out  DATA_W/8; iWM_waitrequest  in  1.
REQ-008 SHALL have ports: WM_done  out  1  level, transfer completed; WM_busy  out  1  transfer in progress; WM_aborted  out  1  level, last transfer aborted.

Function
REQ-009 SHALL implement states IDLE, REQ, LATCH, WRITE; BE = DATA_W/8.
REQ-010 IDLE: Start=1 and Length!=0 -> REQ; latch address, remaining=Length; clear WM_done, WM_aborted; Start with Length=0 ignored.
REQ-011 Start while not IDLE SHALL be ignored.
REQ-012 REQ: FF_readrequest = 1 combinationally for exactly the cycle (state==REQ && !FF_empty), then -> LATCH; FF_empty=1 -> stay REQ.
REQ-013 LATCH: capture FF_q into data register, -> WRITE.
REQ-014 WRITE: oWM_write=1 with address, data, byteenable registered and stable until iWM_waitrequest=0 sampled.
REQ-015 Beat accepted: address += BE; remaining -= min(BE, remaining); remaining<=BE before update -> IDLE with WM_done=1, else -> REQ.
REQ-016 First oWM_write SHALL assert 3 cycles after Start sampled with FIFO non-empty; minimum 4 cycles per beat with no waitrequest.
REQ-017 Abort sampled in REQ or LATCH SHALL -> IDLE with WM_aborted=1, WM_done=0; in LATCH the latched word is discarded.
REQ-018 Abort in WRITE SHALL NOT drop oWM_write; beat completes, then -> IDLE with WM_aborted=1, WM_done=0; Abort wins over normal completion on the same beat.
REQ-019 WM_busy SHALL be 1 in every state except IDLE.
REQ-020 Address arithmetic SHALL wrap modulo 2^ADDR_W; remaining SHALL never underflow.
REQ-021 oWM_write=0 in all states except WRITE; oWM_byteenable=0 when oWM_write=0.

Reset
REQ-022 iReset_n=0 SHALL asynchronously force IDLE and all outputs, counters and data register to 0.
REQ-023 Reset mid-transfer SHALL drop oWM_write immediately; WM_done and WM_aborted SHALL read 0.

Configuration
REQ-024 Macro DMA_WM_PARTIAL_BE_EN defined: final beat with remaining<BE SHALL drive byteenable low 'remaining' bits set, others 0 (e.g. BE=4, remaining=3 -> 4'b0111).
REQ-025 Macro undefined: byteenable SHALL be all ones on every beat; Length effectively rounded up to multiple of BE.

Verification
REQ-026 DATA_W=32, Length=16, addr 0x1000, FIFO 4 words, no wait -> writes at 0x1000/04/08/0C, byteenable 4'hF, WM_done=1.
REQ-027 DATA_W=32, waitrequest high 5 cycles on beat 2 -> address/data/byteenable stable all 6 cycles, single FIFO read per beat.
REQ-028 DMA_WM_PARTIAL_BE_EN, DATA_W=64, Length=13 -> 2 beats, byteenables 8'hFF then 8'h1F; undefined -> 8'hFF, 8'hFF.
REQ-029 FIFO empty 10 cycles in REQ, Abort pulsed -> no write, FF_readrequest never asserted, WM_aborted=1, WM_done=0.
REQ-030 Abort during waitrequest in WRITE -> beat completes on waitrequest=0, then IDLE, WM_aborted=1.
REQ-031 iReset_n low during WRITE at beat 3 of 8 -> all outputs 0 same cycle; new Start after release restarts at new WM_startaddress.

Source files
------------

// File: rtl/dma_write_master_p.sv
// dma_write_master_p -- streams words from a show-ahead-less FIFO onto an
// Avalon-MM write master, one beat per FIFO word.
//
// Beat sequence: REQ pops the FIFO, LATCH captures the word that arrives one
// cycle later, WRITE spends one cycle loading the registered Avalon outputs and
// then holds them until the slave drops waitrequest.  With no backpressure a
// beat therefore costs four cycles.
//
// Optional feature macro: DMA_WM_PARTIAL_BE_EN
//   defined   -> final beat with fewer than BE bytes left drives a partial
//                byteenable (low 'remaining' lanes set)
//   undefined -> every beat drives all byte lanes; the length is effectively
//                rounded up to a whole number of words
module dma_write_master_p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 32
) (
  input  logic                iClk,
  input  logic                iReset_n,
  input  logic                Start,
  input  logic                Abort,
  input  logic [LEN_W-1:0]    Length,
  input  logic [ADDR_W-1:0]   WM_startaddress,
  input  logic                FF_empty,
  output logic                FF_readrequest,
  input  logic [DATA_W-1:0]   FF_q,
  output logic                oWM_write,
  output logic [ADDR_W-1:0]   oWM_writeaddress,
  output logic [DATA_W-1:0]   oWM_writedata,
  output logic [DATA_W/8-1:0] oWM_byteenable,
  input  logic                iWM_waitrequest,
  output logic                WM_done,
  output logic                WM_busy,
  output logic                WM_aborted
);

  localparam int BE = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    LATCH = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  remaining_r;
  logic [DATA_W-1:0] data_r;
  logic [BE-1:0]     be_r;
  logic [BE-1:0]     be_s;
  logic              write_r;
  logic              done_r;
  logic              aborted_r;
  logic              abort_pend_r;
  logic              start_ok_s;
  logic              accept_s;
  logic              last_s;
  logic              abort_any_s;

  // A launch needs an idle engine and a non-zero length.
  assign start_ok_s  = (state_r == IDLE) && Start && (Length != {LEN_W{1'b0}});
  // The slave takes the beat on the first edge it sees write high without wait.
  assign accept_s    = (state_r == WRITE) && write_r && !iWM_waitrequest;
  // This beat covers everything that is left.
  assign last_s      = (remaining_r <= LEN_W'(BE));
  // An Abort seen at any point of the WRITE phase ends the transfer on acceptance.
  assign abort_any_s = Abort || abort_pend_r;

  // The FIFO pop is combinational so the word lands in time for LATCH.
  assign FF_readrequest   = (state_r == REQ) && !FF_empty;

  assign oWM_write        = write_r;
  assign oWM_writeaddress = addr_r;
  assign oWM_writedata    = data_r;
  assign oWM_byteenable   = be_r;
  assign WM_done          = done_r;
  assign WM_aborted       = aborted_r;
  assign WM_busy          = (state_r != IDLE);

  // Byte lanes for the beat about to be presented.
  always_comb begin
    be_s = {BE{1'b1}};
`ifdef DMA_WM_PARTIAL_BE_EN
    if (remaining_r < LEN_W'(BE)) begin
      for (int i = 0; i < BE; i++) begin
        be_s[i] = (LEN_W'(i) < remaining_r);
      end
    end else begin
      be_s = {BE{1'b1}};
    end
`endif
  end

  // State register.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          next_state_s = REQ;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        if (Abort) begin
          next_state_s = IDLE;
        end else if (!FF_empty) begin
          next_state_s = LATCH;
        end else begin
          next_state_s = REQ;
        end
      end
      LATCH: begin
        if (Abort) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = WRITE;
        end
      end
      WRITE: begin
        if (accept_s) begin
          if (abort_any_s || last_s) begin
            next_state_s = IDLE;
          end else begin
            next_state_s = REQ;
          end
        end else begin
          next_state_s = WRITE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Address, length, data and Avalon output registers plus status flags.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      addr_r       <= {ADDR_W{1'b0}};
      remaining_r  <= {LEN_W{1'b0}};
      data_r       <= {DATA_W{1'b0}};
      be_r         <= {BE{1'b0}};
      write_r      <= 1'b0;
      done_r       <= 1'b0;
      aborted_r    <= 1'b0;
      abort_pend_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            addr_r       <= WM_startaddress;
            remaining_r  <= Length;
            done_r       <= 1'b0;
            aborted_r    <= 1'b0;
            abort_pend_r <= 1'b0;
          end
        end
        REQ: begin
          if (Abort) begin
            aborted_r <= 1'b1;
            done_r    <= 1'b0;
          end
        end
        LATCH: begin
          // On Abort the word just popped is dropped rather than captured.
          if (Abort) begin
            aborted_r <= 1'b1;
            done_r    <= 1'b0;
          end else begin
            data_r <= FF_q;
          end
        end
        WRITE: begin
          if (Abort) begin
            abort_pend_r <= 1'b1;
          end
          if (!write_r) begin
            write_r <= 1'b1;
            be_r    <= be_s;
          end else if (!iWM_waitrequest) begin
            write_r     <= 1'b0;
            be_r        <= {BE{1'b0}};
            addr_r      <= addr_r + ADDR_W'(BE);
            remaining_r <= last_s ? {LEN_W{1'b0}} : (remaining_r - LEN_W'(BE));
            if (abort_any_s) begin
              aborted_r    <= 1'b1;
              done_r       <= 1'b0;
              abort_pend_r <= 1'b0;
            end else if (last_s) begin
              done_r <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_write_master_p.sv
// Directed bench for dma_write_master_p (32-bit data path): FIFO model that
// returns data one cycle after the pop, an Avalon slave model with scripted
// waitrequest, and a beat log checked against hand-computed values.
`timescale 1ns/1ps
module tb_dma_write_master_p;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 32;
  localparam int BE     = 4;

  logic              iClk;
  logic              iReset_n;
  logic              Start;
  logic              Abort;
  logic [LEN_W-1:0]  Length;
  logic [ADDR_W-1:0] WM_startaddress;
  logic              FF_empty;
  logic              FF_readrequest;
  logic [DATA_W-1:0] FF_q = 32'd0;
  logic              oWM_write;
  logic [ADDR_W-1:0] oWM_writeaddress;
  logic [DATA_W-1:0] oWM_writedata;
  logic [BE-1:0]     oWM_byteenable;
  logic              iWM_waitrequest = 1'b0;
  logic              WM_done;
  logic              WM_busy;
  logic              WM_aborted;

  int n_chk  = 0;
  int n_fail = 0;

  // FIFO model storage
  logic [31:0] mem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  logic        rd_d   = 1'b0;
  int          rr_cnt = 0;

  // Slave model / beat log
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [3:0]  log_be[$];
  int          log_cyc[$];
  int          log_hi[$];
  int          cyc = 0, wait_cnt = 0, hi_cur = 0, stab_err = 0, stab_n = 0;
  int          wait_beat = -1, wait_len = 0;
  logic        held_v = 1'b0;
  logic [31:0] snap_addr = 32'd0, snap_data = 32'd0;
  logic [3:0]  snap_be = 4'd0;

  assign FF_empty = (wr_ptr == rd_ptr);

  dma_write_master_p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .iClk(iClk), .iReset_n(iReset_n), .Start(Start), .Abort(Abort),
    .Length(Length), .WM_startaddress(WM_startaddress),
    .FF_empty(FF_empty), .FF_readrequest(FF_readrequest), .FF_q(FF_q),
    .oWM_write(oWM_write), .oWM_writeaddress(oWM_writeaddress),
    .oWM_writedata(oWM_writedata), .oWM_byteenable(oWM_byteenable),
    .iWM_waitrequest(iWM_waitrequest),
    .WM_done(WM_done), .WM_busy(WM_busy), .WM_aborted(WM_aborted)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Note each pop request on the edge that takes it.
  always @(posedge iClk) begin
    rd_d <= FF_readrequest;
    if (FF_readrequest) rr_cnt <= rr_cnt + 1;
  end

  // Popped word appears one cycle after the request.
  always @(negedge iClk) begin
    if (rd_d && (rd_ptr != wr_ptr)) begin
      FF_q   = mem[rd_ptr];
      rd_ptr = rd_ptr + 8'd1;
    end
  end

  // Slave: scripted waitrequest, stability tracking and beat logging.
  always @(negedge iClk) begin
    cyc = cyc + 1;
    if (!iReset_n) begin
      held_v = 1'b0; wait_cnt = 0; hi_cur = 0; iWM_waitrequest = 1'b0;
    end else begin
      if (held_v) begin
        stab_n = stab_n + 1;
        if (oWM_writeaddress !== snap_addr || oWM_writedata !== snap_data ||
            oWM_byteenable !== snap_be || oWM_write !== 1'b1) stab_err = stab_err + 1;
      end
      if (oWM_write && (log_addr.size() == wait_beat) && (wait_cnt < wait_len)) begin
        iWM_waitrequest = 1'b1;
        wait_cnt = wait_cnt + 1;
      end else begin
        iWM_waitrequest = 1'b0;
      end
      if (oWM_write) hi_cur = hi_cur + 1;
      held_v    = oWM_write && iWM_waitrequest;
      snap_addr = oWM_writeaddress;
      snap_data = oWM_writedata;
      snap_be   = oWM_byteenable;
      if (oWM_write && !iWM_waitrequest) begin
        log_addr.push_back(oWM_writeaddress);
        log_data.push_back(oWM_writedata);
        log_be.push_back(oWM_byteenable);
        log_cyc.push_back(cyc);
        log_hi.push_back(hi_cur);
        hi_cur = 0;
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [7:0] idx);
    return 32'hC0DE_0000 | {24'd0, idx};
  endfunction

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = exp_word(wr_ptr);
      wr_ptr = wr_ptr + 8'd1;
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] len);
    WM_startaddress = a;
    Length = len;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!WM_busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    if (idx >= log_addr.size()) begin
      chk({tag, "_beat_missing"}, 32'(log_addr.size()), 32'(idx + 1));
    end else begin
      chk({tag, "_addr"}, log_addr[idx], a);
      chk({tag, "_data"}, log_data[idx], d);
      chk({tag, "_be"}, 32'(log_be[idx]), 32'(be));
    end
  endtask

  initial begin
    int base, r0, s0, n0;
    logic [7:0] p0;
    logic found;
    logic [3:0] last_be;

    Start = 1'b0; Abort = 1'b0; Length = 32'd0; WM_startaddress = 32'd0;
    iReset_n = 1'b1;
    #1 iReset_n = 1'b0;
    #2;
    chk("rst_write", 32'(oWM_write), 32'd0);
    chk("rst_be", 32'(oWM_byteenable), 32'd0);
    chk("rst_addr", oWM_writeaddress, 32'd0);
    chk("rst_data", oWM_writedata, 32'd0);
    chk("rst_busy", 32'(WM_busy), 32'd0);
    chk("rst_done", 32'(WM_done), 32'd0);
    chk("rst_aborted", 32'(WM_aborted), 32'd0);
    chk("rst_rdreq", 32'(FF_readrequest), 32'd0);
    tick(); tick();
    iReset_n = 1'b1;
    tick();

    // A: 16 bytes at 0x1000, no backpressure; latency and beat period.
    push_words(4);
    base = log_addr.size(); p0 = rd_ptr; r0 = rr_cnt;
    launch(32'h0000_1000, 32'd16);
    chk("a_busy", 32'(WM_busy), 32'd1);
    chk("a_rdreq_req", 32'(FF_readrequest), 32'd1);
    chk("a_write_c1", 32'(oWM_write), 32'd0);
    tick();
    chk("a_write_c2", 32'(oWM_write), 32'd0);
    chk("a_rdreq_latch", 32'(FF_readrequest), 32'd0);
    tick();
    chk("a_write_c3pre", 32'(oWM_write), 32'd0);
    tick();
    chk("a_write_c3", 32'(oWM_write), 32'd1);
    chk("a_first_addr", oWM_writeaddress, 32'h0000_1000);
    chk("a_first_be", 32'(oWM_byteenable), 32'h0000_000F);
    wait_idle("a");
    for (int i = 0; i < 4; i++)
      chk_beat("a", base + i, 32'h0000_1000 + 32'(4 * i), exp_word(p0 + 8'(i)), 4'hF);
    chk("a_period", (log_cyc.size() > base + 1) ? 32'(log_cyc[base+1] - log_cyc[base]) : 32'hFFFF_FFFF, 32'd4);
    chk("a_done", 32'(WM_done), 32'd1);
    chk("a_aborted", 32'(WM_aborted), 32'd0);
    chk("a_reads", 32'(rr_cnt - r0), 32'd4);
    chk("a_be_idle", 32'(oWM_byteenable), 32'd0);

    // Zero-length Start is ignored and leaves status alone.
    launch(32'h0000_1234, 32'd0);
    chk("z_busy", 32'(WM_busy), 32'd0);
    chk("z_done_kept", 32'(WM_done), 32'd1);

    // B: 5 wait cycles on beat 2; Start while busy is ignored.
    push_words(4);
    base = log_addr.size(); p0 = rd_ptr; r0 = rr_cnt; s0 = stab_err; n0 = stab_n;
    wait_beat = base + 1; wait_len = 5;
    launch(32'h0000_2000, 32'd16);
    chk("b_done_clr", 32'(WM_done), 32'd0);
    tick(); tick();
    WM_startaddress = 32'hDEAD_0000;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_idle("b");
    wait_len = 0;
    for (int i = 0; i < 4; i++)
      chk_beat("b", base + i, 32'h0000_2000 + 32'(4 * i), exp_word(p0 + 8'(i)), 4'hF);
    chk("b_hold_cycles", (log_hi.size() > base + 1) ? 32'(log_hi[base+1]) : 32'd0, 32'd6);
    chk("b_stable_err", 32'(stab_err - s0), 32'd0);
    chk("b_stable_n", 32'(stab_n - n0), 32'd5);
    chk("b_reads", 32'(rr_cnt - r0), 32'd4);
    chk("b_done", 32'(WM_done), 32'd1);

    // C: 13 bytes -> 4 beats; last beat lanes depend on the build option.
`ifdef DMA_WM_PARTIAL_BE_EN
    last_be = 4'h1;
`else
    last_be = 4'hF;
`endif
    push_words(4);
    base = log_addr.size(); p0 = rd_ptr;
    launch(32'h0000_3000, 32'd13);
    wait_idle("c");
    for (int i = 0; i < 3; i++)
      chk_beat("c", base + i, 32'h0000_3000 + 32'(4 * i), exp_word(p0 + 8'(i)), 4'hF);
    chk_beat("c_last", base + 3, 32'h0000_300C, exp_word(p0 + 8'd3), last_be);
    chk("c_count", 32'(log_addr.size() - base), 32'd4);
    chk("c_done", 32'(WM_done), 32'd1);

    // W: address wraps at the top of the space.
    push_words(2);
    base = log_addr.size(); p0 = rd_ptr;
    launch(32'hFFFF_FFFC, 32'd8);
    wait_idle("w");
    chk_beat("w0", base, 32'hFFFF_FFFC, exp_word(p0), 4'hF);
    chk_beat("w1", base + 1, 32'h0000_0000, exp_word(p0 + 8'd1), 4'hF);

    // E: FIFO empty in REQ, then Abort.
    base = log_addr.size(); r0 = rr_cnt;
    launch(32'h0000_4000, 32'd16);
    repeat (10) tick();
    chk("e_busy", 32'(WM_busy), 32'd1);
    chk("e_rdreq", 32'(FF_readrequest), 32'd0);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("e_busy_after", 32'(WM_busy), 32'd0);
    chk("e_aborted", 32'(WM_aborted), 32'd1);
    chk("e_done", 32'(WM_done), 32'd0);
    chk("e_writes", 32'(log_addr.size() - base), 32'd0);
    chk("e_reads", 32'(rr_cnt - r0), 32'd0);

    // F: Abort while the first beat is stalled by waitrequest.
    push_words(4);
    base = log_addr.size(); p0 = rd_ptr; r0 = rr_cnt;
    wait_beat = base; wait_len = 4;
    launch(32'h0000_5000, 32'd16);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (oWM_write && iWM_waitrequest) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("f_stall_seen", 32'(found), 32'd1);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("f_write_held", 32'(oWM_write), 32'd1);
    wait_idle("f");
    wait_len = 0;
    chk("f_count", 32'(log_addr.size() - base), 32'd1);
    chk_beat("f", base, 32'h0000_5000, exp_word(p0), 4'hF);
    chk("f_aborted", 32'(WM_aborted), 32'd1);
    chk("f_done", 32'(WM_done), 32'd0);
    chk("f_reads", 32'(rr_cnt - r0), 32'd1);

    // D: reset while beat 3 of 8 is on the bus, then restart elsewhere.
    push_words(8);
    base = log_addr.size();
    wait_beat = base + 2; wait_len = 50;
    launch(32'h0000_6000, 32'd32);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (oWM_write && (log_addr.size() == base + 2)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("d_beat3_seen", 32'(found), 32'd1);
    iReset_n = 1'b0;
    #1;
    chk("d_rst_write", 32'(oWM_write), 32'd0);
    chk("d_rst_be", 32'(oWM_byteenable), 32'd0);
    chk("d_rst_addr", oWM_writeaddress, 32'd0);
    chk("d_rst_data", oWM_writedata, 32'd0);
    chk("d_rst_busy", 32'(WM_busy), 32'd0);
    chk("d_rst_done", 32'(WM_done), 32'd0);
    chk("d_rst_aborted", 32'(WM_aborted), 32'd0);
    wait_len = 0;
    tick(); tick();
    iReset_n = 1'b1;
    tick();
    base = log_addr.size(); p0 = rd_ptr;
    launch(32'h0000_8000, 32'd8);
    wait_idle("d");
    chk("d_count", 32'(log_addr.size() - base), 32'd2);
    chk_beat("d0", base, 32'h0000_8000, exp_word(p0), 4'hF);
    chk_beat("d1", base + 1, 32'h0000_8004, exp_word(p0 + 8'd1), 4'hF);
    chk("d_done", 32'(WM_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
